// File: rtl/apb_spi_pkg.sv
// Shared constants for the APB-controlled SPI slave: register map, CTRL/STATUS
// bit positions and the SPI engine state encoding.
package apb_spi_pkg;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h04;
  localparam logic [7:0] ADDR_RXDATA = 8'h08;
  localparam logic [7:0] ADDR_TXDATA = 8'h0C;
  localparam logic [7:0] ADDR_LEVEL  = 8'h10;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_LSB_FIRST = 1;
  localparam int CTRL_RX_IE     = 2;
  localparam int CTRL_TX_IE     = 3;
  localparam int CTRL_CLR       = 4;

  localparam int STAT_TX_FULL  = 0;
  localparam int STAT_TX_EMPTY = 1;
  localparam int STAT_RX_FULL  = 2;
  localparam int STAT_RX_EMPTY = 3;
  localparam int STAT_RX_OVF   = 4;
  localparam int STAT_TX_UNF   = 5;
  localparam int STAT_BUSY     = 6;

  typedef enum logic [1:0] {
    ENG_IDLE  = 2'd0,
    ENG_LOAD  = 2'd1,
    ENG_SHIFT = 2'd2
  } eng_state_e;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with occupancy count and synchronous clear; push into a
// full FIFO and pop from an empty one are ignored, judged on pre-cycle state.
module spi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_clr,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_wdata,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // NOTE: storage has no reset; pointers and count alone define validity,
  // which keeps the array as plain RAM without a reset fan-out.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/apb_spi_fifo_slave.sv
// APB register front-end with TX/RX FIFOs feeding a mode-0 SPI slave engine
// that runs on PCLK and oversamples the synchronised SPI pins.
module apb_spi_fifo_slave
  import apb_spi_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int APB_DW     = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [7:0]        PADDR,
  input  logic [APB_DW-1:0] PWDATA,
  output logic [APB_DW-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic              SS_n,
  input  logic              SCK,
  input  logic              MOSI,
  output logic              MISO,
  output logic              MISO_OE,
  output logic              IRQ
);

  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int BCW = $clog2(DATA_W + 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_W);

  logic [2:0]        r_ss_s;
  logic [2:0]        r_sck_s;
  logic [1:0]        r_mosi_s;
  logic [3:0]        r_ctrl;
  logic              r_rx_ovf;
  logic              r_tx_unf;
  logic              r_irq;
  eng_state_e        r_state;
  eng_state_e        w_state_nxt;
  logic [DATA_W-1:0] r_tx_sh;
  logic [DATA_W-1:0] r_rx_sh;
  logic [BCW-1:0]    r_bit_cnt;

  logic              w_access, w_wr, w_rd;
  logic              w_sel_ctrl, w_sel_status, w_sel_rx, w_sel_tx, w_sel_level, w_mapped;
  logic              w_tx_push, w_rx_pop, w_clr;
  logic [1:0]        w_w1c;
  logic              w_en, w_lsb;
  logic              w_ss_sync, w_ss_fall, w_sck_rise, w_sck_fall, w_mosi;
  logic              w_load, w_push_req;
  logic              w_tx_pop, w_rx_push, w_tx_unf_set, w_rx_ovf_set;
  logic [DATA_W-1:0] w_tx_rdata, w_rx_rdata;
  logic              w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic [CW-1:0]     w_tx_count, w_rx_count;
  logic [6:0]        w_status;
  logic [APB_DW-1:0] w_rdata;
  logic              w_unused_pwdata;

  // NOTE: every flop uses <= so all registers update from pre-edge values,
  // independent of the order the simulator evaluates processes.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_ss_s   <= 3'b111;
      r_sck_s  <= 3'b000;
      r_mosi_s <= 2'b00;
    end else begin
      r_ss_s   <= {r_ss_s[1:0], SS_n};
      r_sck_s  <= {r_sck_s[1:0], SCK};
      r_mosi_s <= {r_mosi_s[0], MOSI};
    end
  end

  assign w_ss_sync  = r_ss_s[1];
  assign w_ss_fall  = r_ss_s[2] & ~r_ss_s[1];
  assign w_sck_rise = ~r_sck_s[2] & r_sck_s[1];
  assign w_sck_fall = r_sck_s[2] & ~r_sck_s[1];
  assign w_mosi     = r_mosi_s[1];

  // Bus decode is masked during reset so PRDATA/PSLVERR show idle values.
  assign w_access     = PSEL & PENABLE & PRESETn;
  assign w_wr         = w_access & PWRITE;
  assign w_rd         = w_access & ~PWRITE;
  assign w_sel_ctrl   = (PADDR == ADDR_CTRL);
  assign w_sel_status = (PADDR == ADDR_STATUS);
  assign w_sel_rx     = (PADDR == ADDR_RXDATA);
  assign w_sel_tx     = (PADDR == ADDR_TXDATA);
  assign w_sel_level  = (PADDR == ADDR_LEVEL);
  assign w_mapped     = w_sel_ctrl | w_sel_status | w_sel_rx | w_sel_tx | w_sel_level;

  assign w_tx_push = w_wr & w_sel_tx & ~w_tx_full;
  assign w_rx_pop  = w_rd & w_sel_rx & ~w_rx_empty;
  assign w_clr     = w_wr & w_sel_ctrl & PWDATA[CTRL_CLR];
  assign w_w1c     = (w_wr & w_sel_status) ? PWDATA[STAT_TX_UNF:STAT_RX_OVF] : 2'b00;

  assign PREADY  = 1'b1;
  assign PSLVERR = w_access & (~w_mapped
                             | ( PWRITE & w_sel_tx & w_tx_full)
                             | (~PWRITE & w_sel_rx & w_rx_empty));
  assign w_unused_pwdata = ^PWDATA;

  assign w_en  = r_ctrl[CTRL_EN];
  assign w_lsb = r_ctrl[CTRL_LSB_FIRST];

  assign w_status = {(r_state != ENG_IDLE), r_tx_unf, r_rx_ovf,
                     w_rx_empty, w_rx_full, w_tx_empty, w_tx_full};

  // NOTE: every signal driven here gets a default first so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      case (PADDR)
        ADDR_CTRL:   w_rdata[3:0] = r_ctrl;
        ADDR_STATUS: w_rdata[6:0] = w_status;
        ADDR_RXDATA: if (!w_rx_empty) w_rdata[DATA_W-1:0] = w_rx_rdata;
        ADDR_LEVEL: begin
          w_rdata[7:0]  = 8'(w_rx_count);
          w_rdata[15:8] = 8'(w_tx_count);
        end
        default: w_rdata = '0;
      endcase
    end
  end
  assign PRDATA = w_rdata;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_ctrl   <= '0;
      r_rx_ovf <= 1'b0;
      r_tx_unf <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr && w_sel_ctrl) r_ctrl <= PWDATA[3:0];
      // A same-cycle set beats the W1C clear.
      r_rx_ovf <= w_rx_ovf_set | (r_rx_ovf & ~w_w1c[0]);
      r_tx_unf <= w_tx_unf_set | (r_tx_unf & ~w_w1c[1]);
      r_irq    <= (r_ctrl[CTRL_RX_IE] & ~w_rx_empty) | (r_ctrl[CTRL_TX_IE] & w_tx_empty)
                | r_rx_ovf | r_tx_unf;
    end
  end
  assign IRQ = r_irq;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_state <= ENG_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_push_req  = 1'b0;
    if (!w_en) begin
      w_state_nxt = ENG_IDLE;
    end else begin
      case (r_state)
        ENG_IDLE:  if (w_ss_fall) w_state_nxt = ENG_LOAD;
        ENG_LOAD: begin
          w_load      = 1'b1;
          w_state_nxt = ENG_SHIFT;
        end
        ENG_SHIFT: begin
          // A completed word is kept even if SS_n is already high.
          if (r_bit_cnt == BIT_LAST) begin
            w_push_req  = 1'b1;
            w_state_nxt = ENG_LOAD;
          end else if (w_ss_sync) begin
            w_state_nxt = ENG_IDLE;
          end
        end
        default: w_state_nxt = ENG_IDLE;
      endcase
    end
  end

  assign w_tx_pop     = w_load & ~w_tx_empty;
  assign w_tx_unf_set = w_load & w_tx_empty;
  assign w_rx_push    = w_push_req & ~w_rx_full;
  assign w_rx_ovf_set = w_push_req & w_rx_full;

  // The trailing SCK fall after a word's last rise is not shifted (bit count
  // is 0 again), so a freshly loaded word keeps its first bit on MISO.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_tx_sh   <= '0;
      r_rx_sh   <= '0;
      r_bit_cnt <= '0;
    end else if (w_load) begin
      r_tx_sh   <= w_tx_empty ? '0 : w_tx_rdata;
      r_bit_cnt <= '0;
    end else if (w_en && r_state == ENG_SHIFT) begin
      if (w_sck_rise && r_bit_cnt != BIT_LAST) begin
        r_rx_sh   <= w_lsb ? {w_mosi, r_rx_sh[DATA_W-1:1]} : {r_rx_sh[DATA_W-2:0], w_mosi};
        r_bit_cnt <= r_bit_cnt + BCW'(1);
      end
      if (w_sck_fall && r_bit_cnt != '0) begin
        r_tx_sh <= w_lsb ? {1'b0, r_tx_sh[DATA_W-1:1]} : {r_tx_sh[DATA_W-2:0], 1'b0};
      end
    end
  end

  assign MISO_OE = (r_state != ENG_IDLE);
  assign MISO    = MISO_OE & (w_lsb ? r_tx_sh[0] : r_tx_sh[DATA_W-1]);

  spi_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .i_clr   (w_clr),
    .i_push  (w_tx_push),
    .i_pop   (w_tx_pop),
    .i_wdata (PWDATA[DATA_W-1:0]),
    .o_rdata (w_tx_rdata),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (w_tx_count)
  );

  spi_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .i_clr   (w_clr),
    .i_push  (w_rx_push),
    .i_pop   (w_rx_pop),
    .i_wdata (r_rx_sh),
    .o_rdata (w_rx_rdata),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count (w_rx_count)
  );

endmodule

// File: doc/apb_spi_fifo_slave.md
APB_SPI_FIFO_SLAVE -- requirements
Module: apb_spi_fifo_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 8: SPI frame width in bits, range 4..APB_DW.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: entries per TX/RX FIFO, power of two, minimum 2.
REQ-003 SHALL have parameter APB_DW, default 16: width of PWDATA and PRDATA.
REQ-004 SHALL have port PCLK, input, 1 bit: sole clock.
REQ-005 SHALL have port PRESETn, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have ports PSEL, PENABLE and PWRITE, inputs, 1 bit each: APB control.
REQ-007 SHALL have port PADDR, input, 8 bits: byte address.
REQ-008 SHALL have ports PWDATA (input) and PRDATA (output), APB_DW bits each: APB data.
REQ-009 SHALL have ports PREADY and PSLVERR, outputs, 1 bit each: APB response.
REQ-010 SHALL have ports SS_n, SCK and MOSI, inputs, 1 bit each: asynchronous SPI slave inputs.
REQ-011 SHALL have port MISO, output, 1 bit: SPI data out.
REQ-012 SHALL have port MISO_OE, output, 1 bit: high while a frame is active.
REQ-013 SHALL have port IRQ, output, 1 bit: level interrupt.

Function
REQ-014 SHALL use this register map: 0x00 CTRL (RW); 0x04 STATUS (RO, sticky bits W1C); 0x08 RXDATA (RO, a read pops); 0x0C TXDATA (WO, a write pushes); 0x10 LEVEL (RO).
REQ-015 CTRL bits SHALL be: [0] EN, [1] LSB_FIRST, [2] RX_IE, [3] TX_IE, [4] CLR (self-clearing; a write of 1 empties both FIFOs and reads back 0).
REQ-016 STATUS bits SHALL be: [0] TX_FULL, [1] TX_EMPTY, [2] RX_FULL, [3] RX_EMPTY, [4] RX_OVF (sticky), [5] TX_UNF (sticky), [6] BUSY.
REQ-017 LEVEL SHALL return RX count in [7:0] and TX count in [15:8].
REQ-018 PREADY SHALL be 1 in every access: zero wait states, side effects on the PSEL&PENABLE cycle only.
REQ-019 PRDATA SHALL be combinational in the access phase, zero-extended, and 0 when no read is in progress.
REQ-020 PSLVERR SHALL be asserted for an unmapped address, a TXDATA write while TX_FULL (data dropped), or an RXDATA read while RX_EMPTY (PRDATA=0); in all such cases state is unchanged.
REQ-021 SS_n, SCK and MOSI SHALL pass through two-flop synchronisers before use; edges are detected on synchronised values.
REQ-022 The maximum supported SCK rate SHALL be PCLK/8.
REQ-023 The SPI engine SHALL be SPI mode 0, with bit order MSB first unless LSB_FIRST=1.
REQ-024 Engine states SHALL be IDLE, LOAD and SHIFT.
REQ-025 In IDLE, on a synchronised SS_n fall with EN=1, the engine SHALL go to LOAD.
REQ-026 LOAD SHALL last one cycle: pop TX FIFO into the TX shift register (or load 0 and set TX_UNF if empty), clear the bit counter, then go to SHIFT.
REQ-027 In SHIFT, a synchronised SCK rise SHALL sample MOSI into the RX shift register and increment the bit counter.
REQ-028 In SHIFT, a synchronised SCK fall SHALL advance the TX shift register.
REQ-029 In SHIFT, when the bit counter reaches DATA_W, the engine SHALL push the RX word (or drop it and set RX_OVF if RX_FULL) and go to LOAD.
REQ-030 In SHIFT, an SS_n rise SHALL discard any partial word, with no push and no pop, and return the engine to IDLE.
REQ-031 MISO SHALL equal the current TX shift bit when MISO_OE=1, else 0; MISO_OE and BUSY SHALL equal "state != IDLE".
REQ-032 With EN=0, the engine SHALL be forced to IDLE and ignore SCK, while the FIFOs stay APB-accessible.
REQ-033 A simultaneous push and pop on the same FIFO SHALL both take effect with the count unchanged; full/empty checks use the pre-cycle state.
REQ-034 A W1C write and a same-cycle set of the same sticky bit SHALL leave the bit set.
REQ-035 IRQ SHALL be registered: (RX_IE & !RX_EMPTY) | (TX_IE & TX_EMPTY) | RX_OVF | TX_UNF.

Reset
REQ-036 PRESETn low SHALL asynchronously clear CTRL, the sticky bits, both FIFOs (pointers and counts), the shift registers, the bit counter and the synchronisers (SS_n synchronisers to 1), and place the engine in IDLE.
REQ-037 Outputs during reset SHALL be: PRDATA=0, PSLVERR=0, PREADY=1, MISO=0, MISO_OE=0, IRQ=0.
REQ-038 A reset mid-frame SHALL abort the frame, with no push after release until a new SS_n fall.

Structure
REQ-039 Package apb_spi_pkg SHALL hold the register addresses, the CTRL/STATUS bit indices and the engine state enum.
REQ-040 Sub-module spi_sync_fifo (parameters WIDTH, DEPTH; push, pop, full, empty, count) SHALL be instantiated twice, for TX and RX.

Verification
REQ-041 Write TXDATA 0xA5, then drive an MSB-first frame with MOSI=0x3C -> MISO carries 0xA5; RXDATA reads 0x3C; STATUS shows RX_EMPTY=1 after the read.
REQ-042 Write TXDATA 5 times with FIFO_DEPTH=4 -> the 5th write gets PSLVERR=1, LEVEL[15:8]=4; an RXDATA read while empty -> PSLVERR=1, PRDATA=0.
REQ-043 Send 5 frames without reading -> RX_OVF=1, IRQ=1; W1C 0x10 to STATUS -> RX_OVF=0.
REQ-044 Raise SS_n after 3 bits -> LEVEL unchanged, engine IDLE, the next full frame is received correctly.
REQ-045 Start a frame with an empty TX FIFO -> MISO=0 for all bits, TX_UNF=1; with LSB_FIRST=1, TXDATA 0x01 -> the first MISO bit is 1.
REQ-046 Assert PRESETn low mid-frame -> all outputs at reset values immediately, CTRL reads 0 after release.
